// File: rtl/data_cache_pkg.sv
// Common types and derived widths for the direct-mapped write-back data cache.
`include "data_cache_defines.v"

package data_cache_pkg;

    localparam int DC_AW     = `DC_ADDR_WIDTH;
    localparam int DC_DW     = `DC_DATA_WIDTH;
    localparam int DC_NL     = `DC_NLINES;
    localparam int DC_LW     = `DC_LINE_WORDS;
    localparam int DC_LINE_W = DC_DW * DC_LW;

    typedef enum logic [1:0] {
        ST_IDLE      = `DC_ST_IDLE,
        ST_WRITEBACK = `DC_ST_WRITEBACK,
        ST_FILL      = `DC_ST_FILL
    } dc_state_e;

endpackage

// File: rtl/data_cache_if.sv
// Bundles the load port, store-drain port and memory port of the data cache.
// Handshakes: ld_hit/sb_ack complete a request in the cycle they are high, otherwise the
// requester holds its inputs; mem_req stays high with stable address/data until mem_ready.
interface data_cache_if #(
    parameter int ADDR_WIDTH = `DC_ADDR_WIDTH,
    parameter int DATA_WIDTH = `DC_DATA_WIDTH,
    parameter int LINE_WORDS = `DC_LINE_WORDS
) ();
    logic                             ld_req;
    logic [ADDR_WIDTH-1:0]            ld_addr;
    logic [DATA_WIDTH-1:0]            ld_data;
    logic                             ld_hit;
    logic                             sb_valid;
    logic [ADDR_WIDTH-1:0]            sb_addr;
    logic [DATA_WIDTH-1:0]            sb_data;
    logic                             sb_ack;
    logic                             stall;
    logic                             mem_req;
    logic                             mem_we;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH*LINE_WORDS-1:0] mem_wdata;
    logic [DATA_WIDTH*LINE_WORDS-1:0] mem_rdata;
    logic                             mem_ready;

    modport slave (
        input  ld_req, ld_addr, sb_valid, sb_addr, sb_data, mem_rdata, mem_ready,
        output ld_data, ld_hit, sb_ack, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, sb_valid, sb_addr, sb_data, mem_rdata, mem_ready,
        input  ld_data, ld_hit, sb_ack, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port that
// either updates a single word (marking the line dirty) or installs a clean full line.
module data_cache_array #(
    parameter int NLINES     = `DC_NLINES,
    parameter int LINE_WORDS = `DC_LINE_WORDS,
    parameter int DATA_WIDTH = `DC_DATA_WIDTH,
    parameter int TAG_W      = `DC_TAG_WIDTH,
    localparam int INDEX_W   = $clog2(NLINES),
    localparam int WORD_W    = $clog2(LINE_WORDS),
    localparam int LINE_W    = DATA_WIDTH * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_W-1:0]     rd_line_o,
    input  logic                  we_word_i,
    input  logic                  we_fill_i,
    input  logic [INDEX_W-1:0]    wr_index_i,
    input  logic [WORD_W-1:0]     wr_word_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [LINE_W-1:0]     wr_line_i
);
    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_fill_i) begin
            valid_q[wr_index_i] <= 1'b1;
            dirty_q[wr_index_i] <= 1'b0;
        end else if (we_word_i) begin
            dirty_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we_fill_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end else if (we_word_i) begin
            data_q[wr_index_i][wr_word_i*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];
endmodule

// File: rtl/data_cache_defines.v
// Shared width and state-encoding macros for the data cache, used by RTL and bench.
// Derived widths must stay consistent with the base parameters below.
`ifndef DATA_CACHE_DEFINES_V
`define DATA_CACHE_DEFINES_V

`define DC_ADDR_WIDTH    32
`define DC_DATA_WIDTH    32
`define DC_NLINES        4
`define DC_LINE_WORDS    4

`define DC_INDEX_WIDTH   2
`define DC_WORD_WIDTH    2
`define DC_OFFSET_WIDTH  4
`define DC_TAG_WIDTH     26
`define DC_LINE_BITS     128

`define DC_ST_IDLE       2'd0
`define DC_ST_WRITEBACK  2'd1
`define DC_ST_FILL       2'd2

`endif

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: load/store arbitration,
// miss FSM (writeback of dirty victim, then line fill) and the memory interface.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = `DC_ADDR_WIDTH,
    parameter int DATA_WIDTH = `DC_DATA_WIDTH,
    parameter int NLINES     = `DC_NLINES,
    parameter int LINE_WORDS = `DC_LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    data_cache_if.slave       bus,
    output dc_state_e         dbg_state_o
);
    localparam int INDEX_W = $clog2(NLINES);
    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int OFF_W   = WORD_W + $clog2(DATA_WIDTH / 8);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - OFF_W;
    localparam int LINE_W  = DATA_WIDTH * LINE_WORDS;

    dc_state_e             state_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [LINE_W-1:0]     mem_wdata_q;

    logic                  in_idle, req_any, hit, miss;
    logic [ADDR_WIDTH-1:0] req_addr, look_addr;
    logic [INDEX_W-1:0]    look_index;
    logic [WORD_W-1:0]     look_word;
    logic [TAG_W-1:0]      look_tag;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_byte_bits;

    assign in_idle  = (state_q == ST_IDLE);
    assign req_any  = bus.ld_req | bus.sb_valid;
    // A load wins arbitration; a concurrent store drain simply waits.
    assign req_addr = bus.ld_req ? bus.ld_addr : bus.sb_addr;
    // While a miss is outstanding the array is looked up at the held miss address.
    assign look_addr  = in_idle ? req_addr : miss_addr_q;
    assign look_index = look_addr[OFF_W +: INDEX_W];
    assign look_word  = look_addr[OFF_W-1 -: WORD_W];
    assign look_tag   = look_addr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_byte_bits = ^look_addr[OFF_W-WORD_W-1:0];

    data_cache_array #(
        .NLINES     (NLINES),
        .LINE_WORDS (LINE_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (reset),
        .rd_index_i (look_index),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .we_word_i  (bus.sb_ack),
        .we_fill_i  ((state_q == ST_FILL) && bus.mem_ready),
        .wr_index_i (look_index),
        .wr_word_i  (look_word),
        .wr_data_i  (bus.sb_data),
        .wr_tag_i   (look_tag),
        .wr_line_i  (bus.mem_rdata)
    );

    assign hit     = rd_valid && (rd_tag == look_tag);
    assign rd_word = rd_line[look_word*DATA_WIDTH +: DATA_WIDTH];
    assign miss    = in_idle && req_any && !hit;

    assign bus.ld_hit    = in_idle && bus.ld_req && hit;
    assign bus.ld_data   = bus.ld_hit ? rd_word : '0;
    assign bus.sb_ack    = in_idle && !bus.ld_req && bus.sb_valid && hit;
    assign bus.stall     = !in_idle || miss;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        miss_addr_q <= req_addr;
                        mem_req_q   <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q     <= ST_WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {rd_tag, look_index, {OFF_W{1'b0}}};
                            mem_wdata_q <= rd_line;
                        end else begin
                            state_q    <= ST_FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state_q     <= ST_FILL;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_addr_q  <= {miss_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_FILL: begin
                    if (bus.mem_ready) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: fill, store hit, dirty writeback, arbitration, reset mid-fill.
`include "data_cache_defines.v"

module tb_data_cache;
  import data_cache_pkg::*;

  localparam int AW = `DC_ADDR_WIDTH;
  localparam int DW = `DC_DATA_WIDTH;
  localparam int LB = `DC_LINE_BITS;

  logic      clk;
  logic      rst;
  dc_state_e dbg_state;
  int        n_cmp;
  int        n_err;

  data_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(`DC_LINE_WORDS)) bus ();

  data_cache dut (
    .clk         (clk),
    .reset       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.ld_req    = 1'b0;
    bus.ld_addr   = '0;
    bus.sb_valid  = 1'b0;
    bus.sb_addr   = '0;
    bus.sb_data   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_hit",    bus.ld_hit, 0);
    chk("rst_sb_ack",    bus.sb_ack, 0);
    chk("rst_stall",     bus.stall, 0);
    chk("rst_mem_req",   bus.mem_req, 0);
    chk("rst_mem_we",    bus.mem_we, 0);
    chk("rst_ld_data",   bus.ld_data, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_state",     dbg_state, ST_IDLE);
    rst = 1'b0;

    // Load miss at 0xAA, clean victim, fill returns on the third FILL cycle
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h0000_00AA;
    settle();
    chk("t1_detect_stall", bus.stall, 1);
    chk("t1_detect_hit",   bus.ld_hit, 0);
    chk("t1_detect_req",   bus.mem_req, 0);
    tick();
    chk("t1_fill_state", dbg_state, ST_FILL);
    chk("t1_fill_req",   bus.mem_req, 1);
    chk("t1_fill_we",    bus.mem_we, 0);
    chk("t1_fill_addr",  bus.mem_addr, 32'h0000_00A0);
    chk("t1_fill_stall", bus.stall, 1);
    tick();
    chk("t1_fill2_addr", bus.mem_addr, 32'h0000_00A0);
    tick();
    bus.mem_rdata = {32'h0000_1003, 32'h0000_1234, 32'h0000_1001, 32'h0000_1000};
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    settle();
    chk("t1_replay_hit",   bus.ld_hit, 1);
    chk("t1_replay_data",  bus.ld_data, 32'h0000_1234);
    chk("t1_replay_stall", bus.stall, 0);
    chk("t1_replay_req",   bus.mem_req, 0);

    // mem_ready while idle is ignored
    bus.ld_req    = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    settle();
    chk("idle_ready_state", dbg_state, ST_IDLE);
    chk("idle_ready_req",   bus.mem_req, 0);

    // Store hit at 0xAA, then read back via 0xA8
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h0000_00AA;
    bus.sb_data  = 32'h0000_DDDD;
    settle();
    chk("t2_sb_ack",   bus.sb_ack, 1);
    chk("t2_sb_stall", bus.stall, 0);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h0000_00A8;
    settle();
    chk("t2_ld_hit",  bus.ld_hit, 1);
    chk("t2_ld_data", bus.ld_data, 32'h0000_DDDD);
    tick();

    // Store miss at 0xEA evicts dirty 0xA0 line
    bus.ld_req   = 1'b0;
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h0000_00EA;
    bus.sb_data  = 32'h0000_FFFF;
    settle();
    chk("t3_detect_ack",   bus.sb_ack, 0);
    chk("t3_detect_stall", bus.stall, 1);
    tick();
    chk("t3_wb_state", dbg_state, ST_WRITEBACK);
    chk("t3_wb_req",   bus.mem_req, 1);
    chk("t3_wb_we",    bus.mem_we, 1);
    chk("t3_wb_addr",  bus.mem_addr, 32'h0000_00A0);
    chk("t3_wb_word2", bus.mem_wdata[95:64], 32'h0000_DDDD);
    chk("t3_wb_line",  bus.mem_wdata,
        {32'h0000_1003, 32'h0000_DDDD, 32'h0000_1001, 32'h0000_1000});
    tick();
    chk("t3_wb_hold_addr", bus.mem_addr, 32'h0000_00A0);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    settle();
    chk("t3_fill_state", dbg_state, ST_FILL);
    chk("t3_fill_we",    bus.mem_we, 0);
    chk("t3_fill_addr",  bus.mem_addr, 32'h0000_00E0);
    chk("t3_fill_ack",   bus.sb_ack, 0);
    bus.mem_rdata = {32'h0000_2003, 32'h0000_2002, 32'h0000_2001, 32'h0000_2000};
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    settle();
    chk("t3_replay_ack", bus.sb_ack, 1);
    chk("t3_replay_req", bus.mem_req, 0);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h0000_00E8;
    settle();
    chk("t3_ld_store", bus.ld_data, 32'h0000_FFFF);
    bus.ld_addr = 32'h0000_00E0;
    settle();
    chk("t3_ld_fill", bus.ld_data, 32'h0000_2000);

    // Load and store together, both hitting
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h0000_00E4;
    bus.sb_data  = 32'h0000_5555;
    settle();
    chk("t4_ld_hit",  bus.ld_hit, 1);
    chk("t4_ld_data", bus.ld_data, 32'h0000_2000);
    chk("t4_sb_ack",  bus.sb_ack, 0);
    tick();
    bus.ld_req = 1'b0;
    settle();
    chk("t4_sb_ack_next", bus.sb_ack, 1);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h0000_00E4;
    settle();
    chk("t4_ld_store", bus.ld_data, 32'h0000_5555);

    // Reset during FILL abandons the miss and invalidates everything
    bus.ld_addr = 32'h0000_0010;
    tick();
    chk("t5_fill_req", bus.mem_req, 1);
    rst = 1'b1;
    settle();
    chk("t5_rst_req",   bus.mem_req, 0);
    chk("t5_rst_state", dbg_state, ST_IDLE);
    bus.ld_req = 1'b0;
    tick();
    rst = 1'b0;
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h0000_00A8;
    settle();
    chk("t5_post_hit",   bus.ld_hit, 0);
    chk("t5_post_stall", bus.stall, 1);
    tick();
    chk("t5_post_req",  bus.mem_req, 1);
    chk("t5_post_addr", bus.mem_addr, 32'h0000_00A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache that sits directly downstream of the store buffer in the basic processor's memory stage. It serves loads from the memory stage and drained stores from the store buffer, and acknowledges each accepted store back to the store buffer. Misses are handled by a small FSM that writes back a dirty victim and refills the line from main memory over a request/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; loads and stores are word-granular.
- NLINES, 4, number of cache lines (power of two).
- LINE_WORDS, 4, words per line; the line is 128 bits at the defaults.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ld_req  in  1  memory stage requests a load.
- ld_addr  in  ADDR_WIDTH  load byte address; bits [1:0] ignored.
- ld_data  out  DATA_WIDTH  load result; valid when ld_hit=1.
- ld_hit  out  1  load served this cycle.
- sb_valid  in  1  store buffer presents a drain (its sending_data_to_cache).
- sb_addr  in  ADDR_WIDTH  store byte address; bits [1:0] ignored.
- sb_data  in  DATA_WIDTH  store data.
- sb_ack  out  1  store written this cycle; the store buffer pops its head on this (its cache_hit input).
- stall  out  1  a miss is in progress; requesters hold their inputs stable.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = line writeback, 0 = line read.
- mem_addr  out  ADDR_WIDTH  line-aligned address; low log2(LINE_WORDS)+2 bits are zero.
- mem_wdata  out  DATA_WIDTH*LINE_WORDS  victim line.
- mem_rdata  in  DATA_WIDTH*LINE_WORDS  fill line.
- mem_ready  in  1  memory completes the current transaction this cycle.

## Operation
- Address split at the defaults: word = addr[3:2], index = addr[5:4], tag = addr[31:6].
- Per line state: valid, dirty, tag, data.
- FSM states:
  - IDLE: serves the arbitrated request. On a hit, a load drives ld_data/ld_hit combinationally; a store writes the word, sets dirty and asserts sb_ack. On a miss, the miss address is latched; the FSM goes to WRITEBACK if the victim is valid and dirty, otherwise to FILL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}. Holds until mem_ready, then goes to FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr = miss line. On mem_ready the line is installed with valid=1, dirty=0 and the new tag; the FSM returns to IDLE.
- Replay: the held request re-arbitrates in IDLE the next cycle and hits. A store miss then writes the word (write-allocate).
- Arbitration: a load has priority over a store drain. When both are present, sb_ack=0 and the store waits.
- A store followed by a load to the same word on the next cycle returns the stored data.
- stall=1 in WRITEBACK and FILL, and combinationally in IDLE on a miss of the arbitrated request.
- ld_hit, sb_ack and mem_* are 0 whenever the corresponding condition is false; no output is X.

## Timing
- Reset: all valid/dirty bits = 0, FSM = IDLE. ld_hit, sb_ack, stall, mem_req and mem_we = 0; ld_data, mem_addr and mem_wdata = 0. Data and tag array contents are don't-care.
- Reset mid-miss: mem_req drops asynchronously and the transaction is abandoned; the memory model must tolerate this.
- Hit latency: load data in the same cycle. A store is committed at the edge that ends the cycle in which sb_ack=1.
- Miss latency (clean victim): 1 (detect) + Nfill cycles + 1 (replay hit), where Nfill is the number of FILL cycles up to and including the one with mem_ready.
- Miss latency (dirty victim): adds the WRITEBACK cycles up to and including mem_ready.
- mem_ready seen in IDLE is ignored.
- mem_addr and mem_wdata are stable for the whole time mem_req=1.

## Structure
- Shared defines header data_cache_defines.v, `include-d by the RTL and the bench: `DC_ADDR_WIDTH, `DC_DATA_WIDTH, `DC_NLINES, `DC_LINE_WORDS, derived index/offset widths, and FSM state encodings. This header follows the same macro style as the store buffer widths.
- One sub-module, data_cache_array: the tag/valid/dirty/data storage with one read port and one write port (a word write or a full-line fill).
- Top level: FSM, arbitration and the memory interface.

## Test plan
- Reset, then load 0x000000AA → stall=1, FILL issued with mem_addr=0x000000A0; mem returns a line with word 2 = 0x1234 after 3 cycles → replay gives ld_hit=1, ld_data=0x1234.
- sb_valid with addr 0x000000AA, data 0x0000DDDD after that fill → sb_ack=1 in 1 cycle; next-cycle load of 0xA8 returns 0x0000DDDD.
- Store 0x0000FFFF to 0x000000EA (same index, different tag) while the 0xA0 line is dirty → WRITEBACK with mem_addr=0xA0 and mem_wdata word 2 = 0xDDDD, then FILL of 0xE0, then sb_ack.
- ld_req and sb_valid in the same cycle, both hitting → ld_hit=1, sb_ack=0; the store is acked the following cycle.
- Assert reset during FILL → mem_req=0 immediately; afterwards a load of 0xA8 misses because all lines are invalid.
